// File: rtl/seg7_scan_drv.sv
// Four-digit multiplexed 7-segment driver: scan prescaler, digit rotator with dead time,
// hex decoder, optional leading-zero suppression, and frame-aligned double buffering.
module seg7_scan_drv #(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 2,
    parameter bit          ACT_LOW   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] din,
    input  logic        din_vld,
    input  logic [3:0]  dp_en,
    input  logic        blank_lz,
    output logic [7:0]  seg,
    output logic [3:0]  sel,
    output logic        upd_ack
);

    localparam int unsigned   CW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] DIV_MAX = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_V = CW'(BLANK_CYC);
    localparam logic [7:0]    SEG_OFF = ACT_LOW ? 8'hFF : 8'h00;
    localparam logic [3:0]    SEL_OFF = ACT_LOW ? 4'hF : 4'h0;

    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]    dig_q, dig_d;
    logic [15:0]   disp_q, disp_d;
    logic [15:0]   pnd_q, pnd_d;
    logic          pnd_flag_q, pnd_flag_d;
    logic          upd_ack_q, upd_ack_d;
    logic [7:0]    seg_q, seg_d;
    logic [3:0]    sel_q, sel_d;

    logic          wrap;
    logic          frame_end;
    logic          in_dead;
    logic [3:0]    lz_mask;
    logic [3:0]    nib;
    logic          lit;
    logic [7:0]    seg_raw;
    logic [3:0]    sel_raw;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    assign wrap      = (div_cnt_q == DIV_MAX);
    assign frame_end = wrap && (dig_q == 2'd3);

    generate
        if (BLANK_CYC == 0) begin : g_no_dead
            assign in_dead = 1'b0;
        end else begin : g_dead
            assign in_dead = (div_cnt_q < BLANK_V);
        end
    endgenerate

    // lz_mask[k]: nibble k and all higher nibbles are zero; digit 0 is never suppressed.
    assign lz_mask[3] = (disp_q[15:12] == 4'h0);
    assign lz_mask[2] = lz_mask[3] && (disp_q[11:8] == 4'h0);
    assign lz_mask[1] = lz_mask[2] && (disp_q[7:4] == 4'h0);
    assign lz_mask[0] = 1'b0;

    // din_vld is a strobe with no back-pressure: every asserted cycle is accepted into
    // pnd (last one wins) and is only promoted to disp at a later frame boundary.
    always_comb begin
        div_cnt_d  = wrap ? '0 : div_cnt_q + CW'(1);
        dig_d      = wrap ? dig_q + 2'd1 : dig_q;
        pnd_d      = din_vld ? din : pnd_q;
        disp_d     = disp_q;
        pnd_flag_d = pnd_flag_q;
        upd_ack_d  = 1'b0;
        if (frame_end && pnd_flag_q) begin
            disp_d     = pnd_q;
            pnd_flag_d = 1'b0;
            upd_ack_d  = 1'b1;
        end
        if (din_vld) begin
            pnd_flag_d = 1'b1;
        end
    end

    always_comb begin
        nib     = disp_q[{dig_q, 2'b00} +: 4];
        lit     = !in_dead && !(blank_lz && lz_mask[dig_q]);
        seg_raw = 8'h00;
        sel_raw = 4'h0;
        if (lit) begin
            seg_raw = {dp_en[dig_q], hex7(nib)};
            sel_raw = 4'b0001 << dig_q;
        end
        seg_d = seg_raw ^ SEG_OFF;
        sel_d = sel_raw ^ SEL_OFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q  <= '0;
            dig_q      <= 2'd0;
            disp_q     <= 16'h0000;
            pnd_q      <= 16'h0000;
            pnd_flag_q <= 1'b0;
            upd_ack_q  <= 1'b0;
            seg_q      <= SEG_OFF;
            sel_q      <= SEL_OFF;
        end else begin
            div_cnt_q  <= div_cnt_d;
            dig_q      <= dig_d;
            disp_q     <= disp_d;
            pnd_q      <= pnd_d;
            pnd_flag_q <= pnd_flag_d;
            upd_ack_q  <= upd_ack_d;
            seg_q      <= seg_d;
            sel_q      <= sel_d;
        end
    end

    assign seg     = seg_q;
    assign sel     = sel_q;
    assign upd_ack = upd_ack_q;

endmodule

// File: tb/tb_seg7_scan_drv.sv
// Bench for seg7_scan_drv with SCAN_DIV=4, BLANK_CYC=1, ACT_LOW=1: table of display
// vectors checked slot by slot over a whole frame, plus reset/collision sequences.
module tb_seg7_scan_drv;

    localparam int SCAN_DIV  = 4;
    localparam int BLANK_CYC = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] din = 16'h0000;
    logic        din_vld = 1'b0;
    logic [3:0]  dp_en = 4'h0;
    logic        blank_lz = 1'b0;
    logic [7:0]  seg;
    logic [3:0]  sel;
    logic        upd_ack;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0]      din;
        logic             lz;
        logic [3:0]       dp;
        logic [3:0][7:0]  eseg;
        logic [3:0][3:0]  esel;
    } vec_t;

    vec_t vecs[8];
    vec_t v_zero, v_2222, v_3333;

    seg7_scan_drv #(
        .SCAN_DIV (SCAN_DIV),
        .BLANK_CYC(BLANK_CYC),
        .ACT_LOW  (1'b1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (din),
        .din_vld (din_vld),
        .dp_en   (dp_en),
        .blank_lz(blank_lz),
        .seg     (seg),
        .sel     (sel),
        .upd_ack (upd_ack)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [15:0] d, input logic lz, input logic [3:0] dp,
                                input logic [31:0] s, input logic [15:0] l);
        vec_t v;
        v.din  = d;
        v.lz   = lz;
        v.dp   = dp;
        v.eseg = s;
        v.esel = l;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives the strobe at the current negedge and returns one negedge later.
    task automatic strobe(input logic [15:0] d, input logic lz, input logic [3:0] dp);
        din      = d;
        blank_lz = lz;
        dp_en    = dp;
        din_vld  = 1'b1;
        @(negedge clk);
        din_vld  = 1'b0;
    endtask

    task automatic wait_ack(input string name);
        int n;
        n = 0;
        while (upd_ack !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, " upd_ack"}, {7'd0, upd_ack}, 8'h01);
    endtask

    // Called at the negedge where upd_ack is (or would be) visible; walks the next 16 slots.
    task automatic check_frame(input vec_t v, input string tag);
        int d;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            d = k / 4;
            if (k % 4 == 0) begin
                chk($sformatf("%s dead seg k=%0d", tag, k), seg, 8'hFF);
                chk($sformatf("%s dead sel k=%0d", tag, k), {4'h0, sel}, 8'h0F);
            end else begin
                chk($sformatf("%s seg k=%0d", tag, k), seg, v.eseg[d]);
                chk($sformatf("%s sel k=%0d", tag, k), {4'h0, sel}, {4'h0, v.esel[d]});
            end
            if (k < 15) chk($sformatf("%s no ack k=%0d", tag, k), {7'd0, upd_ack}, 8'h00);
        end
    endtask

    initial begin
        int acks;
        vecs[0] = mk(16'h1A2F, 1'b0, 4'h0, {~8'h06, ~8'h77, ~8'h5B, ~8'h71}, 16'h7BDE);
        vecs[1] = mk(16'h0005, 1'b1, 4'h0, {8'hFF, 8'hFF, 8'hFF, ~8'h6D}, 16'hFFFE);
        vecs[2] = mk(16'h0000, 1'b1, 4'h0, {8'hFF, 8'hFF, 8'hFF, ~8'h3F}, 16'hFFFE);
        vecs[3] = mk(16'h0008, 1'b0, 4'b0100, {~8'h3F, ~8'hBF, ~8'h3F, ~8'h7F}, 16'h7BDE);
        vecs[4] = mk(16'hC0DE, 1'b1, 4'hF, {~8'hB9, ~8'hBF, ~8'hDE, ~8'hF9}, 16'h7BDE);
        vecs[5] = mk(16'h0450, 1'b1, 4'b1000, {8'hFF, ~8'h66, ~8'h6D, ~8'h3F}, 16'hFBDE);
        vecs[6] = mk(16'h89B3, 1'b0, 4'h0, {~8'h7F, ~8'h6F, ~8'h7C, ~8'h4F}, 16'h7BDE);
        vecs[7] = mk(16'h4567, 1'b0, 4'h0, {~8'h66, ~8'h6D, ~8'h7D, ~8'h07}, 16'h7BDE);
        v_zero  = mk(16'h0000, 1'b0, 4'h0, {4{~8'h3F}}, 16'h7BDE);
        v_2222  = mk(16'h2222, 1'b0, 4'h0, {4{~8'h5B}}, 16'h7BDE);
        v_3333  = mk(16'h3333, 1'b0, 4'h0, {4{~8'h4F}}, 16'h7BDE);

        // Reset held for three cycles, then the idle display of 0000.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset seg", seg, 8'hFF);
            chk("reset sel", {4'h0, sel}, 8'h0F);
            chk("reset ack", {7'd0, upd_ack}, 8'h00);
        end
        rst_n = 1'b1;
        check_frame(v_zero, "post-reset");

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            strobe(vecs[i].din, vecs[i].lz, vecs[i].dp);
            wait_ack($sformatf("vec%0d", i));
            check_frame(vecs[i], $sformatf("vec%0d", i));
        end

        // Two strobes in one frame: only the last is shown, with one ack.
        @(negedge clk);
        strobe(16'h1111, 1'b0, 4'h0);
        repeat (2) @(negedge clk);
        strobe(16'h2222, 1'b0, 4'h0);
        wait_ack("last-wins");
        check_frame(v_2222, "last-wins");
        chk("last-wins single ack", {7'd0, upd_ack}, 8'h00);

        // Strobe in the boundary cycle is deferred by one frame.
        repeat (15) @(negedge clk);
        strobe(16'h3333, 1'b0, 4'h0);
        chk("collision no ack", {7'd0, upd_ack}, 8'h00);
        check_frame(v_2222, "collision held");
        chk("collision late ack", {7'd0, upd_ack}, 8'h01);
        check_frame(v_3333, "collision new");

        // Asynchronous reset during the digit 2 slot with a value pending.
        repeat (9) @(negedge clk);
        strobe(16'h7777, 1'b0, 4'h0);
        chk("pre-reset sel digit2", {4'h0, sel}, 8'h0B);
        rst_n = 1'b0;
        #1;
        chk("async reset seg", seg, 8'hFF);
        chk("async reset sel", {4'h0, sel}, 8'h0F);
        chk("async reset ack", {7'd0, upd_ack}, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_frame(v_zero, "after mid reset");
        acks = (upd_ack === 1'b1) ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (upd_ack === 1'b1) acks++;
        end
        chk("no ack after mid reset", 8'(acks), 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_drv.md
# seg7_scan_drv

Four-digit multiplexed 7-segment display driver that consumes a 16-bit value, normally four 4-bit counter nibbles, and shows it as hexadecimal on a common-select LED display. The block contains:
- a programmable scan prescaler;
- a digit rotator with dead-time blanking;
- a hex-to-segment decoder;
- optional leading-zero suppression.

Incoming values are double-buffered, so a display frame never mixes old and new digits.

## Interface
- SCAN_DIV, default 50000: clk cycles per digit slot; legal range 2..2^20.
- BLANK_CYC, default 2: cycles at the start of each slot with all selects off (anti-ghosting); legal range 0..SCAN_DIV-1.
- ACT_LOW, default 1: 1 means seg and sel are active-low; 0 means active-high.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- din  in  16  value to display; din[3:0] is digit 0 (rightmost), din[15:12] is digit 3.
- din_vld  in  1  single-cycle strobe; captures din into the pending register.
- dp_en  in  4  decimal-point enable per digit; sampled live, not buffered.
- blank_lz  in  1  1 enables leading-zero suppression; sampled live.
- seg  out  8  seg[7] is dp, seg[6:0] are segments g..a; registered.
- sel  out  4  digit select, one-hot (polarity per ACT_LOW); registered.
- upd_ack  out  1  one-cycle pulse when a pending value becomes displayed.

## Operation
- **Pending register:**
  - din_vld=1 loads din into pnd and sets pnd_flag.
  - With several strobes before a frame boundary, the last strobe wins.
- **Scan counter:**
  - div_cnt counts 0..SCAN_DIV-1 and wraps.
  - On wrap, dig advances 0→1→2→3→0.
- **Frame boundary:** the cycle with div_cnt==SCAN_DIV-1 and dig==3.
  - If pnd_flag=1, disp<=pnd, pnd_flag<=0, and upd_ack is asserted on the next cycle.
  - A din_vld in the boundary cycle is not applied at that boundary. It loads pnd, pnd_flag stays or becomes 1, and the value is applied at the following boundary.
- **Decode:**
  - Segment patterns are given active-high, a=bit0.
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - seg[7] = dp_en[dig].
- **Leading-zero suppression (blank_lz=1):**
  - Digit k (k=3..1) is blanked when disp nibble k and every higher nibble are 0.
  - Digit 0 is never blanked.
  - A blanked digit has sel and seg both fully off, including dp.
- **Dead time:** for div_cnt < BLANK_CYC, sel is all off and seg is all off.
- **ACT_LOW=1:** seg and sel are bitwise inverted at the output register.

## Timing
- **Reset values:**
  - div_cnt=0, dig=0, disp=0, pnd=0, pnd_flag=0, upd_ack=0.
  - seg=all off (8'hFF when ACT_LOW=1, 8'h00 otherwise).
  - sel=all off (4'hF when ACT_LOW=1, 4'h0 otherwise).
- **Output registration:** outputs are registered. seg/sel reflect the dig/div_cnt state of the previous cycle, giving a 1-cycle decode latency.
- **Reset release:** digit 0 slot begins. The first sel assertion occurs BLANK_CYC+1 cycles after the first clk edge with rst_n high.
- **Update latency:**
  - A boundary at cycle T applies disp at T.
  - upd_ack=1 at T+1 only.
  - Digit 0 of the new value appears on seg from T+1+BLANK_CYC.
  - Worst-case latency from din_vld to display is 4*SCAN_DIV+BLANK_CYC+1 cycles.
- **Frame period:** exactly 4*SCAN_DIV cycles; each digit is lit for SCAN_DIV-BLANK_CYC cycles.
- **din_vld with no boundary:** pnd_flag stays set indefinitely and disp is unchanged.
- **Reset mid-frame:**
  - All state clears immediately and asynchronously.
  - A pending value is discarded and no upd_ack is issued.
- **Counter width:** div_cnt width is clog2(SCAN_DIV). There is no overflow beyond SCAN_DIV-1.

## Test plan
All scenarios use SCAN_DIV=4 and BLANK_CYC=1.
- **Reset:** hold rst_n low 3 cycles with ACT_LOW=1 → seg=8'hFF, sel=4'hF, upd_ack=0. After release, sel=4'hE (digit 0) from the 2nd cycle, seg=~8'h3F.
- **Update, blank_lz=0:** din=16'h1A2F with din_vld for 1 cycle → upd_ack pulses once at the next frame boundary +1. The following frame shows digits 0..3 = ~71, ~06(?)… precisely: digit0 ~8'h71, digit1 ~8'h5B, digit2 ~8'h77, digit3 ~8'h06, each lit 3 of 4 cycles.
- **Leading zeros:** blank_lz=1, din=16'h0005 → digits 3..1 have sel=4'hF and seg=8'hFF during their slots; digit 0 shows ~8'h6D. Then din=16'h0000 → only digit 0 is lit, showing ~8'h3F.
- **Last-wins and boundary collision:**
  - Strobe 16'h1111 then 16'h2222 within one frame → only 2222 is displayed, with a single upd_ack.
  - Strobe 16'h3333 exactly in the boundary cycle → 2222 stays for one frame, then 3333 appears with a second upd_ack.
- **Decimal point:** dp_en=4'b0100, din=16'h0008, blank_lz=0 → seg[7] is active only in the digit 2 slot; all other slots have dp off.
- **Reset mid-operation:** assert rst_n during the digit 2 slot with pnd_flag=1 → outputs go off in the same cycle (async). After release, 0000 is displayed and no upd_ack occurs.
